spi_cmd_decoder: RTL

- Consumes the 64-bit words delivered by the SPI word receiver and interprets them as framed host commands: a header word, then a payload of N words.
- Implements a small bank of 64-bit control registers that the host can write and read back over the same full-duplex link.
- Drives the word-send data that the SPI word transmitter shifts out on the next word.
- Sits between the SPI word layer and the motion/config logic, which consumes the register outputs.

---
 rtl/spi_cmd_pkg.sv | 30 +++
 rtl/spi_cmd_decoder_if.sv | 20 ++
 rtl/rising_edge_detector.sv | 16 +
 rtl/spi_cmd_decoder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, header layout, FSM states and status-word packing for the
// SPI command decoder.
package spi_cmd_pkg;

  localparam logic [7:0] OP_NOP        = 8'h00;
  localparam logic [7:0] OP_WRITE      = 8'h01;
  localparam logic [7:0] OP_READ       = 8'h02;
  localparam logic [7:0] OP_STATUS_CLR = 8'h03;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  localparam int HDR_OP_LSB   = 56;
  localparam int HDR_ADDR_LSB = 48;
  localparam int HDR_LEN_LSB  = 32;

  typedef enum logic [1:0] {
    IDLE,
    WRITE_DATA,
    READ_DATA,
    DRAIN
  } state_t;

  function automatic logic [63:0] status_word(input logic [7:0]  magic,
                                              input logic        err,
                                              input logic [15:0] cnt,
                                              input logic [31:0] status);
    return {magic, 7'b0, err, cnt, status};
  endfunction

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Word-level link between the SPI word receiver/transmitter and the decoder.
interface spi_cmd_decoder_if #(
  parameter int W = 64
);
  logic         word_received;
  logic [W-1:0] word_data_received;
  logic [W-1:0] word_send_data;

  modport master (
    output word_received,
    output word_data_received,
    input  word_send_data
  );

  modport slave (
    input  word_received,
    input  word_data_received,
    output word_send_data
  );
endinterface

// File: rtl/rising_edge_detector.sv
// One-cycle pulse on each low-to-high transition of a synchronous level.
module rising_edge_detector (
  input  logic clk,
  input  logic resetn,
  input  logic level,
  output logic pulse
);
  logic level_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) level_q <= 1'b0;
    else         level_q <= level;
  end

  assign pulse = level & ~level_q;
endmodule

// File: rtl/spi_cmd_decoder.sv
// Framed host-command decoder: header + N payload words drive a bank of
// 64-bit control registers with read-back over the full-duplex SPI word link.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int         W     = 64,
  parameter int         NREGS = 16,
  parameter logic [7:0] MAGIC = MAGIC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 CS,
  spi_cmd_decoder_if.slave     word_if,
  input  logic [31:0]          status_in,
  output logic [NREGS*W-1:0]   reg_out,
  output logic [NREGS-1:0]     reg_wr_strobe,
  output logic                 err_sticky,
  output logic                 busy
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic             cs_meta, cs_high;
  logic             wr_evt;
  state_t           state, state_nxt;
  logic [AW-1:0]    ptr, ptr_nxt;
  logic [15:0]      rem, rem_nxt;
  logic [15:0]      cnt, cnt_nxt;
  logic             err, err_nxt;
  logic [W-1:0]     send, send_nxt;
  logic             wr_en, load_status;
  logic [NREGS-1:0] strobe, strobe_nxt;
  logic [W-1:0]     regs [NREGS];

  logic [7:0]       hdr_op, hdr_addr;
  logic [15:0]      hdr_len;
  logic             addr_ok, ptr_last;

  // CS is asynchronous to clk; reset to the deasserted level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cs_meta <= 1'b1;
      cs_high <= 1'b1;
    end else begin
      cs_meta <= CS;
      cs_high <= cs_meta;
    end
  end

  rising_edge_detector u_word_edge (
    .clk    (clk),
    .resetn (resetn),
    .level  (word_if.word_received),
    .pulse  (wr_evt)
  );

  assign hdr_op   = word_if.word_data_received[HDR_OP_LSB   +: 8];
  assign hdr_addr = word_if.word_data_received[HDR_ADDR_LSB +: 8];
  assign hdr_len  = word_if.word_data_received[HDR_LEN_LSB  +: 16];
  assign addr_ok  = ({24'd0, hdr_addr} < 32'(NREGS));
  assign ptr_last = (ptr == AW'(NREGS - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      ptr    <= '0;
      rem    <= '0;
      cnt    <= '0;
      err    <= 1'b0;
      send   <= status_word(MAGIC, 1'b0, 16'd0, 32'd0);
      strobe <= '0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      rem    <= rem_nxt;
      cnt    <= cnt_nxt;
      err    <= err_nxt;
      send   <= send_nxt;
      strobe <= strobe_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    rem_nxt     = rem;
    cnt_nxt     = cnt;
    err_nxt     = err;
    send_nxt    = send;
    wr_en       = 1'b0;
    load_status = 1'b0;

    // A deasserted CS overrides any word arriving on the same edge.
    if (cs_high) begin
      if (state != IDLE) err_nxt = 1'b1;
      state_nxt = IDLE;
      rem_nxt   = '0;
    end else if (wr_evt) begin
      case (state)
        IDLE: begin
          cnt_nxt = cnt + 16'd1;
          if (hdr_op == OP_STATUS_CLR) begin
            err_nxt = 1'b0;
          end else if (hdr_op == OP_WRITE || hdr_op == OP_READ) begin
            if (!addr_ok) begin
              err_nxt = 1'b1;
              if (hdr_len != 16'd0) begin
                state_nxt = DRAIN;
                rem_nxt   = hdr_len;
              end
            end else if (hdr_len != 16'd0) begin
              ptr_nxt = hdr_addr[AW-1:0];
              rem_nxt = hdr_len;
              if (hdr_op == OP_WRITE) begin
                state_nxt = WRITE_DATA;
              end else begin
                state_nxt = READ_DATA;
                send_nxt  = regs[hdr_addr[AW-1:0]];
              end
            end
          end else if (hdr_op != OP_NOP) begin
            err_nxt = 1'b1;
            if (hdr_len != 16'd0) begin
              state_nxt = DRAIN;
              rem_nxt   = hdr_len;
            end
          end
        end
        WRITE_DATA: begin
          wr_en       = 1'b1;
          load_status = 1'b1;
          ptr_nxt     = ptr + AW'(1);
          rem_nxt     = rem - 16'd1;
          if (rem == 16'd1) begin
            state_nxt = IDLE;
          end else if (ptr_last) begin
            err_nxt   = 1'b1;
            state_nxt = DRAIN;
          end
        end
        READ_DATA: begin
          ptr_nxt = ptr + AW'(1);
          rem_nxt = rem - 16'd1;
          if (rem == 16'd1) begin
            state_nxt   = IDLE;
            load_status = 1'b1;
          end else if (ptr_last) begin
            err_nxt     = 1'b1;
            state_nxt   = DRAIN;
            load_status = 1'b1;
          end else begin
            send_nxt = regs[ptr + AW'(1)];
          end
        end
        DRAIN: begin
          load_status = 1'b1;
          rem_nxt     = rem - 16'd1;
          if (rem == 16'd1) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Status is built from the post-edge err/count so a STATUS_CLR shows at once.
    if (state_nxt == IDLE || load_status)
      send_nxt = status_word(MAGIC, err_nxt, cnt_nxt, status_in);
  end

  assign strobe_nxt = wr_en ? (NREGS'(1) << ptr) : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[ptr] <= word_if.word_data_received;
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_out
    assign reg_out[i*W +: W] = regs[i];
  end

  assign word_if.word_send_data = send;
  assign reg_wr_strobe          = strobe;
  assign err_sticky             = err;
  assign busy                   = (state != IDLE);

endmodule
